// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 1250;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } uart_state_t;
`endif

    // Even parity: 1 when the byte has an odd number of ones.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts down from CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    // Reload on every restart (state entry / bit boundary), otherwise count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= RELOAD;
        end else begin
            count <= count - 16'd1;
        end
    end

    assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_guess.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_guess
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow
);

    uart_state_t state;
    logic [7:0]  hold_data;
    logic        hold_valid;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        bit_end;
    logic        restart;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    // The timer is held at reload while idle and restarted at each bit boundary,
    // so every state entry sees a fresh full bit period.
    assign restart  = (state == IDLE) || bit_end;
    assign load     = hold_valid && ((state == IDLE) || ((state == STOP) && bit_end));
    assign tx_ready = !hold_valid;
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && bit_end;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .bit_end(bit_end)
    );

    // Holding register: accept when empty, drop and flag when full, empty on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_overflow <= tx_send && hold_valid;
            if (load) begin
                hold_valid <= 1'b0;
            end else if (tx_send && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_data;
            end
        end
    end

    // Frame sequencer; tx is registered alongside the state so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (load) begin
            state   <= START;
            tx      <= 1'b0;
            shift   <= hold_data;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(hold_data);
`endif
        end else if (bit_end) begin
            case (state)
                START: begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= parity_bit;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        shift <= shift >> 1;
                        tx    <= shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
                IDLE: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_guess.sv
// Self-checking bench for uart_tx_guess: directed steps with random bytes, checked against
// a behavioural line decoder and frame-bit model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_guess;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME_CYC = NBITS * CPB;

    logic       tb_clk  = 1'b0;
    logic       rst     = 1'b1;
    logic       tx_send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, tx_busy, tx_done, tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         bad_frames = 0;
    int         done_cnt   = 0;
    int         ovf_cnt    = 0;

    uart_tx_guess #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overflow(tx_overflow)
    );

    always #5 tb_clk = ~tb_clk;

    // Expected line level for frame bit i: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i - 1];
        if (i == int'(NBITS) - 1) return 1'b1;
        return ($countones(b) % 2) == 1;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic send(input logic [7:0] b);
        tx_data = b;
        tx_send = 1'b1;
        @(negedge tb_clk);
        tx_send = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_start(input int unsigned limit, output int unsigned waited);
        waited = 0;
        while (tx !== 1'b0 && waited < limit) begin
            @(negedge tb_clk);
            waited++;
        end
        chk_bit("start_seen", tx, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < int'(4 * FRAME_CYC) && quiet < 3; i++) begin
            @(negedge tb_clk);
            if (tx_busy === 1'b0 && tx_ready === 1'b1 && tx === 1'b1) quiet++;
            else quiet = 0;
        end
        chk_bit(tag, quiet >= 3, 1'b1);
    endtask

    // Pulse counters for tx_done / tx_overflow.
    initial forever begin
        @(negedge tb_clk);
        if (tx_done === 1'b1) done_cnt++;
        if (tx_overflow === 1'b1) ovf_cnt++;
    end

    // Line decoder: samples mid-bit like a receiver and queues good bytes.
    initial begin : rx_model
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge tb_clk);
            if (mon_en && !rst && tx === 1'b0) begin
                ok = 1'b1;
                repeat (CPB / 2) @(negedge tb_clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge tb_clk);
                    b[k] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge tb_clk);
                if (tx !== (($countones(b) % 2) == 1)) ok = 1'b0;
`endif
                repeat (CPB) @(negedge tb_clk);
                if (tx !== 1'b1) ok = 1'b0;
                repeat (CPB - CPB / 2 - 1) @(negedge tb_clk);
                if (ok) rx_q.push_back(b);
                else bad_frames++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned w;
        int          d0, o0, bad0, dcount;
        logic        all_high;
        logic [7:0]  a, b2, drop, c;

        // Reset held for two cycles.
        tick(2);
        chk_bit("rst_tx", tx, 1'b1);
        chk_bit("rst_ready", tx_ready, 1'b1);
        chk_bit("rst_busy", tx_busy, 1'b0);
        chk_bit("rst_done", tx_done, 1'b0);
        chk_bit("rst_ovf", tx_overflow, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Single frame 'O', checked cycle by cycle.
        rx_q.delete();
        bad0 = bad_frames;
        send(8'h4F);
        chk_bit("single_ready_low", tx_ready, 1'b0);
        wait_start(8, w);
        chk_val("single_start_latency", 32'(w), 32'd1);
        dcount = 0;
        for (int cy = 0; cy < int'(FRAME_CYC); cy++) begin
            chk_bit("single_tx", tx, frame_bit(8'h4F, cy / int'(CPB)));
            chk_bit("single_busy", tx_busy, 1'b1);
            chk_bit("single_done", tx_done, cy == int'(FRAME_CYC) - 1);
            if (tx_done === 1'b1) dcount++;
            @(negedge tb_clk);
        end
        chk_val("single_done_count", 32'(dcount), 32'd1);
        chk_bit("single_end_tx", tx, 1'b1);
        chk_bit("single_end_busy", tx_busy, 1'b0);
        wait_idle("single_idle");
        chk_val("single_rx_size", 32'(rx_q.size()), 32'd1);
        chk_val("single_rx_byte", 32'(rx_q[0]), 32'h4F);

        // Back-to-back frames: second byte queued during DATA.
        rx_q.delete();
        d0 = done_cnt;
        send(8'h4D);
        wait_start(8, w);
        tick(3 * CPB);
        send(8'h50);
        chk_bit("b2b_ready_low", tx_ready, 1'b0);
        w = 0;
        while (tx_done !== 1'b1 && w < 2 * FRAME_CYC) begin
            @(negedge tb_clk);
            w++;
        end
        chk_bit("b2b_first_done", tx_done, 1'b1);
        tick(1);
        chk_bit("b2b_no_gap_tx", tx, 1'b0);
        chk_bit("b2b_no_gap_busy", tx_busy, 1'b1);
        wait_idle("b2b_idle");
        chk_val("b2b_rx_size", 32'(rx_q.size()), 32'd2);
        chk_val("b2b_rx0", 32'(rx_q[0]), 32'h4D);
        chk_val("b2b_rx1", 32'(rx_q[1]), 32'h50);
        chk_val("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // Overflow: shifter busy, holding full, extra byte dropped.
        for (int it = 0; it < 3; it++) begin
            a    = 8'($urandom);
            b2   = 8'($urandom);
            drop = (it == 0) ? 8'h45 : 8'($urandom);
            rx_q.delete();
            o0 = ovf_cnt;
            send(a);
            wait_start(8, w);
            tick(CPB);
            send(b2);
            chk_bit("ovf_ready_low", tx_ready, 1'b0);
            send(drop);
            chk_bit("ovf_pulse", tx_overflow, 1'b1);
            tick(1);
            chk_bit("ovf_one_cycle", tx_overflow, 1'b0);
            wait_idle("ovf_idle");
            chk_val("ovf_rx_size", 32'(rx_q.size()), 32'd2);
            chk_val("ovf_rx0", 32'(rx_q[0]), 32'(a));
            chk_val("ovf_rx1", 32'(rx_q[1]), 32'(b2));
            chk_val("ovf_count", 32'(ovf_cnt - o0), 32'd1);
        end

        // Mid-frame reset during DATA bit 3 with a byte queued.
        mon_en = 1'b0;
        send(8'h4D);
        wait_start(8, w);
        send(8'h50);
        tick(16);
        rst = 1'b1;
        @(negedge tb_clk);
        chk_bit("midrst_tx", tx, 1'b1);
        chk_bit("midrst_busy", tx_busy, 1'b0);
        chk_bit("midrst_ready", tx_ready, 1'b1);
        chk_bit("midrst_done", tx_done, 1'b0);
        rst = 1'b0;
        all_high = 1'b1;
        for (int cy = 0; cy < int'(FRAME_CYC); cy++) begin
            @(negedge tb_clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) all_high = 1'b0;
        end
        chk_bit("midrst_queue_lost", all_high, 1'b1);
        mon_en = 1'b1;
        rx_q.delete();
        c = 8'($urandom);
        send(c);
        wait_idle("midrst_after_idle");
        chk_val("midrst_after_size", 32'(rx_q.size()), 32'd1);
        chk_val("midrst_after_byte", 32'(rx_q[0]), 32'(c));

        // Reset wins over a simultaneous send.
        rst     = 1'b1;
        tx_send = 1'b1;
        tx_data = 8'($urandom);
        @(negedge tb_clk);
        rst     = 1'b0;
        tx_send = 1'b0;
        chk_bit("rstprio_ready", tx_ready, 1'b1);
        all_high = 1'b1;
        for (int cy = 0; cy < int'(3 * CPB); cy++) begin
            @(negedge tb_clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) all_high = 1'b0;
        end
        chk_bit("rstprio_no_frame", all_high, 1'b1);

        chk_val("bad_frames", 32'(bad_frames - bad0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
